// File: rtl/bcd_to_binary.sv
// Sequential 4-digit packed-BCD to 14-bit binary converter.
// Digits are folded in most-significant first as acc = acc*10 + digit, one per clock,
// behind a start/busy/done handshake. Nibbles above 9 short-circuit to an error result.
module bcd_to_binary (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bcd,
    output logic [13:0] binary,
    output logic        done,
    output logic        busy,
    output logic        error
);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e      state_q, state_d;
    logic [13:0] acc_q, acc_d;
    logic [13:0] acc_step;
    logic [15:0] sr_q, sr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [13:0] binary_q, binary_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        error_q, error_d;

    logic        accept;
    logic        bcd_invalid;

    // A request is only honoured when no conversion is running.
    assign accept = start && ((state_q == StIdle) || (state_q == StDone));

    assign bcd_invalid = (bcd[15:12] > 4'd9) || (bcd[11:8] > 4'd9) ||
                         (bcd[7:4]   > 4'd9) || (bcd[3:0]  > 4'd9);

    // acc*10 as (acc<<3)+(acc<<1); 999*10+9 = 9999 so 14 bits never overflow.
    assign acc_step = (acc_q << 3) + (acc_q << 1) + {10'd0, sr_q[15:12]};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d = bcd_invalid ? StDone : StConv;
                end
            end
            StConv: begin
                if (cnt_q == 2'd3) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        acc_d    = acc_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        binary_d = binary_q;
        done_d   = done_q;
        busy_d   = busy_q;
        error_d  = error_q;
        if (accept) begin
            sr_d    = bcd;
            acc_d   = 14'd0;
            cnt_d   = 2'd0;
            done_d  = 1'b0;
            error_d = 1'b0;
            if (bcd_invalid) begin
                // Error result is immediate; binary is forced to 0 with it.
                done_d   = 1'b1;
                error_d  = 1'b1;
                binary_d = 14'd0;
                busy_d   = 1'b0;
            end else begin
                busy_d = 1'b1;
            end
        end else if (state_q == StConv) begin
            acc_d = acc_step;
            sr_d  = sr_q << 4;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                binary_d = acc_step;
                done_d   = 1'b1;
                busy_d   = 1'b0;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= 14'd0;
            sr_q     <= 16'd0;
            cnt_q    <= 2'd0;
            binary_q <= 14'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            binary_q <= binary_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            error_q  <= error_d;
        end
    end

    assign binary = binary_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign error  = error_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed cases plus random requests,
// checked against a decimal-digit reference model.
module tb_bcd_to_binary;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bcd;
    logic [13:0] binary;
    logic        done;
    logic        busy;
    logic        error;

    int checks = 0;
    int errors = 0;
    int prev_binary = 0;

    bcd_to_binary dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bcd    (bcd),
        .binary (binary),
        .done   (done),
        .busy   (busy),
        .error  (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: decimal value of the four digits, and whether every digit is 0..9.
    function automatic void model(input logic [15:0] v, output int val, output bit valid);
        int d;
        val   = 0;
        valid = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            d = int'((v >> (4 * i)) & 16'hF);
            if (d > 9) valid = 1'b0;
            val = val * 10 + d;
        end
    endfunction

    // Called at a negedge; issues a request and checks it through to the result.
    // When noise is set, start/bcd are randomised during CONV and must have no effect.
    task automatic run_conv(input logic [15:0] v, input bit noise, input string tag);
        int  exp_val;
        bit  valid;
        model(v, exp_val, valid);
        start = 1'b1;
        bcd   = v;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bcd   = 16'($urandom);
        if (!valid) begin
            check({tag, ".err_done"},   32'(done),   32'd1);
            check({tag, ".err_flag"},   32'(error),  32'd1);
            check({tag, ".err_binary"}, 32'(binary), 32'd0);
            check({tag, ".err_busy"},   32'(busy),   32'd0);
            prev_binary = 0;
            return;
        end
        for (int c = 1; c <= 4; c++) begin
            check({tag, ".busy"},      32'(busy),   32'd1);
            check({tag, ".done_low"},  32'(done),   32'd0);
            check({tag, ".hold_bin"},  32'(binary), 32'(prev_binary));
            if (noise) begin
                start = 1'($urandom);
                bcd   = 16'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, ".busy_end"}, 32'(busy),   32'd0);
        check({tag, ".done"},     32'(done),   32'd1);
        check({tag, ".error"},    32'(error),  32'd0);
        check({tag, ".binary"},   32'(binary), 32'(exp_val));
        prev_binary = exp_val;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bcd   = 16'd0;
        repeat (2) @(negedge clk);
        check("rst.binary", 32'(binary), 32'd0);
        check("rst.done",   32'(done),   32'd0);
        check("rst.busy",   32'(busy),   32'd0);
        check("rst.error",  32'(error),  32'd0);
        reset = 1'b0;

        run_conv(16'h1234, 1'b0, "d1234");
        check("d1234.hex", 32'(binary), 32'h04D2);
        run_conv(16'h9999, 1'b0, "d9999");
        check("d9999.hex", 32'(binary), 32'h270F);
        run_conv(16'h0000, 1'b0, "d0000");
        run_conv(16'h12A4, 1'b0, "d12A4");

        // Second request during CONV cycle 2 must be ignored.
        start = 1'b1;
        bcd   = 16'h0042;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        bcd   = 16'h0777;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("ign.done",   32'(done),   32'd1);
        check("ign.binary", 32'(binary), 32'd42);
        check("ign.busy",   32'(busy),   32'd0);
        prev_binary = 42;

        // Asynchronous reset in the middle of CONV cycle 3.
        start = 1'b1;
        bcd   = 16'h0500;
        @(posedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst.binary", 32'(binary), 32'd0);
        check("arst.done",   32'(done),   32'd0);
        check("arst.busy",   32'(busy),   32'd0);
        check("arst.error",  32'(error),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        prev_binary = 0;
        run_conv(16'h0007, 1'b0, "after_rst");

        // Back-to-back: second start on the edge right after done rises.
        run_conv(16'h0010, 1'b0, "b2b_a");
        run_conv(16'h0020, 1'b0, "b2b_b");
        // Invalid requests have a 1-clock period.
        run_conv(16'hF000, 1'b0, "bad_a");
        run_conv(16'h000B, 1'b0, "bad_b");

        // Random requests: mostly valid BCD, some raw 16-bit values.
        for (int n = 0; n < 40; n++) begin
            logic [15:0] v;
            if ($urandom_range(3) == 0) begin
                v = 16'($urandom);
            end else begin
                v = {4'($urandom_range(9)), 4'($urandom_range(9)),
                     4'($urandom_range(9)), 4'($urandom_range(9))};
            end
            if ($urandom_range(1) == 1) @(negedge clk);
            run_conv(v, 1'b1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Sequential decimal-to-binary converter: accepts a 4-digit packed BCD value (0–9999) and produces the equivalent 14-bit binary value by multiply-by-10-and-add, one digit per clock. It is the inverse of the display path's divide-by-10 digit extraction. It feeds keypad/decimal entry back into the binary counters that drive the display. It has a start/busy/done handshake and flags any nibble that is not a valid decimal digit.

## Interface
- No parameters; widths are fixed at 4 digits in and 14 bits out.
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high; clears all state and outputs
- start  input  1  conversion request, sampled on rising clk; honoured only in IDLE or DONE
- bcd  input  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units; sampled on the accepting edge only
- binary  output  14  converted value; valid while done=1
- done  output  1  result valid; held until next accepted start or reset
- busy  output  1  conversion in progress; start ignored while high
- error  output  1  a nibble of the accepted bcd was >9; valid with done

## Operation
- States:
  - IDLE: after reset.
  - CONV: 4 cycles, digit counter 0..3.
  - DONE
- Reset, asynchronous: state=IDLE; binary=0, done=0, busy=0, error=0; accumulator, digit shift register and counter all 0.
- Accept: start=1 on an edge in IDLE or DONE.
  - On that edge: capture bcd into the shift register; clear accumulator, done and error.
- Validity check on capture. If any nibble is >9:
  - go directly to DONE on the accepting edge;
  - error=1, done=1, binary=0, busy stays 0.
- Otherwise, on the accepting edge: state=CONV, busy=1.
- CONV step, each edge, digits taken most-significant first:
  - acc_next = (acc<<3) + (acc<<1) + top nibble;
  - shift register shifts left by 4;
  - counter increments.
- On the 4th CONV edge:
  - binary=acc_next, done=1, busy=0, state=DONE.
- Arithmetic: accumulator is 14 bits unsigned. The largest intermediate value is 999·10+9=9999=0x270F, so it never overflows. There is no saturation logic.
- start while busy=1: ignored, no effect on the running conversion. bcd changes during CONV have no effect.
- start in DONE: accepted as a new request, so back-to-back conversions have no idle cycle.
- binary holds its last value through CONV of the next request. It is cleared only by reset or an error result. Only done qualifies it.

## Timing
- Edge E0 accepts start. Edges E1..E4 process the thousands, hundreds, tens and units digits.
- done/binary are valid after E4: latency 4 clocks from the accepting edge.
- busy is high from after E0 to after E4, exactly 4 cycles.
- Error path: done=1 and error=1 immediately after E0, 0 cycles of busy.
- Minimum request period: 5 clocks for valid input (start high at E4+1 is accepted), 1 clock for invalid input.
- reset asserted at any time, including mid-CONV: outputs go 0 asynchronously. The first acceptable start is on the first edge after reset deasserts.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset released, start with bcd=0x1234:
  - busy=1 for exactly 4 cycles;
  - then done=1, binary=14'd1234 (0x04D2), error=0.
- bcd=0x9999 → binary=0x270F after 4 cycles. bcd=0x0000 → binary=0, done=1, error=0.
- bcd=0x12A4 → on the accepting edge: done=1, error=1, binary=0, busy never asserts.
- Start 0x0042; pulse start with bcd=0x0777 during cycle 2 of CONV → result is 42, the second request is ignored.
- Start 0x0500; assert reset during CONV cycle 3 → binary/done/busy/error all 0 immediately. After release, start 0x0007 → binary=7.
- Back-to-back conversions: start 0x0010, then start 0x0020 on the edge immediately after done rises.
  - done drops for 4 cycles, then binary=20.
  - binary shows 10 until the second done.
